mul_seq_ctrl: RTL and testbench

//  Sequential radix-4 multiply controller for the MiniAlu datapath. It shares one 4:1

---
 rtl/mul_seq_pkg.sv | 21 ++
 rtl/mul_pp_select.sv | 26 ++
 rtl/mul_seq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mul_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the sequential radix-4 multiply controller.
package mul_seq_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StFix   = 2'd2,
    StWrite = 2'd3
  } state_e;

  localparam logic [1:0] PP_ZERO = 2'd0;
  localparam logic [1:0] PP_X1   = 2'd1;
  localparam logic [1:0] PP_X2   = 2'd2;
  localparam logic [1:0] PP_X3   = 2'd3;

  // Number of radix-4 digit cycles for a given operand width.
  function automatic int unsigned iter(input int unsigned width);
    return width / 2;
  endfunction

endpackage

// File: rtl/mul_pp_select.sv
// Shared radix-4 partial-product selector: 0, A, 2A or 3A chosen by a 2-bit multiplier digit.
module mul_pp_select
  import mul_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [1:0]       digit_i,
  output logic [WIDTH+1:0] pp_o
);

  logic [WIDTH+1:0] a_ext;
  assign a_ext = {2'b00, a_i};

  always_comb begin
    pp_o = '0;
    unique case (digit_i)
      PP_ZERO: pp_o = '0;
      PP_X1:   pp_o = a_ext;
      PP_X2:   pp_o = a_ext << 1;
      PP_X3:   pp_o = a_ext + (a_ext << 1);
      default: pp_o = '0;
    endcase
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential radix-4 multiply controller: one digit per cycle, then writes both product halves.
// Define MUL_SEQ_SIGNED_EN for two's-complement operands (adds a one-cycle sign-fix state).
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [WIDTH-1:0]  operand_a_i,
  input  logic [WIDTH-1:0]  operand_b_i,
  input  logic [ADDR_W-1:0] dest_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              write_enable_o,
  output logic              mul_enable_o,
  output logic [ADDR_W-1:0] write_address_o,
  output logic [WIDTH-1:0]  result_lo_o,
  output logic [WIDTH-1:0]  result_hi_o
);

  localparam int unsigned ITER = iter(WIDTH);
  localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ITER - 1);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [2*WIDTH-1:0]  acc_q, acc_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]   dest_q, dest_d;
`ifdef MUL_SEQ_SIGNED_EN
  logic                sign_q, sign_d;
`endif

  logic [WIDTH+1:0]    pp;
  logic [WIDTH+1:0]    sum;

  logic                busy_q, done_q, we_q, me_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [WIDTH-1:0]    lo_q, hi_q;

  mul_pp_select #(
    .WIDTH (WIDTH)
  ) u_pp_select (
    .a_i     (a_q),
    .digit_i (b_q[1:0]),
    .pp_o    (pp)
  );

  // Upper half plus partial product never exceeds WIDTH+2 bits.
  assign sum = {2'b00, acc_q[2*WIDTH-1:WIDTH]} + pp;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dest_d  = dest_q;
`ifdef MUL_SEQ_SIGNED_EN
    sign_d  = sign_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
`ifdef MUL_SEQ_SIGNED_EN
          a_d    = operand_a_i[WIDTH-1] ? -operand_a_i : operand_a_i;
          b_d    = operand_b_i[WIDTH-1] ? -operand_b_i : operand_b_i;
          sign_d = operand_a_i[WIDTH-1] ^ operand_b_i[WIDTH-1];
`else
          a_d    = operand_a_i;
          b_d    = operand_b_i;
`endif
          dest_d  = dest_i;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (abort_i) begin
          state_d = StIdle;
        end else begin
          acc_d = {sum, acc_q[WIDTH-1:2]};
          b_d   = {2'b00, b_q[WIDTH-1:2]};
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
`ifdef MUL_SEQ_SIGNED_EN
            state_d = StFix;
`else
            state_d = StWrite;
`endif
          end
        end
      end
      StFix: begin
`ifdef MUL_SEQ_SIGNED_EN
        if (abort_i) begin
          state_d = StIdle;
        end else begin
          if (sign_q) acc_d = -acc_q;
          state_d = StWrite;
        end
`else
        state_d = StIdle;
`endif
      end
      StWrite: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      dest_q  <= '0;
`ifdef MUL_SEQ_SIGNED_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dest_q  <= dest_d;
`ifdef MUL_SEQ_SIGNED_EN
      sign_q  <= sign_d;
`endif
    end
  end

  // Outputs are registered off the current state, so they trail the FSM by one cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      we_q   <= 1'b0;
      me_q   <= 1'b0;
      addr_q <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
    end else begin
      busy_q <= (state_q != StIdle);
      done_q <= (state_q == StWrite);
      we_q   <= (state_q == StWrite);
      me_q   <= (state_q == StWrite);
      addr_q <= dest_q;
      if (state_q == StWrite) begin
        lo_q <= acc_q[WIDTH-1:0];
        hi_q <= acc_q[2*WIDTH-1:WIDTH];
      end
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign write_enable_o  = we_q;
  assign mul_enable_o    = me_q;
  assign write_address_o = addr_q;
  assign result_lo_o     = lo_q;
  assign result_hi_o     = hi_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl; honours MUL_SEQ_SIGNED_EN when defined.
module tb_mul_seq_ctrl;

`ifdef MUL_SEQ_SIGNED_EN
  localparam int LAT = 10;
`else
  localparam int LAT = 9;
`endif
  localparam int WIN = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic [7:0]  dest = '0;
  logic        busy, done, we, me;
  logic [7:0]  waddr;
  logic [15:0] res_lo, res_hi;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mul_seq_ctrl #(
    .WIDTH  (16),
    .ADDR_W (8)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .abort_i         (abort),
    .operand_a_i     (op_a),
    .operand_b_i     (op_b),
    .dest_i          (dest),
    .busy_o          (busy),
    .done_o          (done),
    .write_enable_o  (we),
    .mul_enable_o    (me),
    .write_address_o (waddr),
    .result_lo_o     (res_lo),
    .result_hi_o     (res_hi)
  );

  function automatic logic [31:0] model_product(input logic [15:0] a, input logic [15:0] b);
    longint p;
`ifdef MUL_SEQ_SIGNED_EN
    p = longint'($signed(a)) * longint'($signed(b));
`else
    p = longint'({16'b0, a}) * longint'({16'b0, b});
`endif
    return p[31:0];
  endfunction

  // Launches one operation and records what the DUT does over a fixed window.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [7:0] d,
                        input logic abort_with_start, input int abort_at,
                        input int restart0, input int restart1,
                        output int first_done, output int n_done, output int busy_err,
                        output logic [15:0] lo, output logic [15:0] hi, output logic [7:0] addr);
    int busy_last;
    op_a = a; op_b = b; dest = d; start = 1'b1; abort = abort_with_start;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    op_a = 16'($urandom); op_b = 16'($urandom); dest = 8'($urandom);
    first_done = -1; n_done = 0; busy_err = 0; lo = '0; hi = '0; addr = '0;
    busy_last = (abort_at > 0) ? abort_at : LAT;
    for (int n = 1; n <= WIN; n++) begin
      start = (n == restart0) || (n == restart1);
      abort = (n == abort_at);
      @(posedge clk); #1;
      if (done) begin
        n_done++;
        if (first_done < 0) begin
          first_done = n; lo = res_lo; hi = res_hi; addr = waddr;
        end
      end
      if (we !== done || me !== done) busy_err++;
      if (busy !== (n <= busy_last)) busy_err++;
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset;
    tests_run++;
    if ({busy, done, we, me} !== 4'b0 || waddr !== 8'h0 || res_lo !== 16'h0 || res_hi !== 16'h0)
    begin
      tests_failed++;
      $display("FAIL reset_outputs: got busy/done/we/me=%b addr=%h lo=%h hi=%h, expected all 0",
               {busy, done, we, me}, waddr, res_lo, res_hi);
    end
  endtask

  task automatic check_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic [7:0] d, input logic abort_with_start);
    int fd, nd, be;
    logic [15:0] lo, hi;
    logic [7:0] ad;
    logic [31:0] exp;
    exp = model_product(a, b);
    run_op(a, b, d, abort_with_start, -1, -1, -1, fd, nd, be, lo, hi, ad);
    tests_run++;
    if (fd != LAT || nd != 1 || be != 0) begin
      tests_failed++;
      $display("FAIL %s_timing: got done_cycle=%0d dones=%0d flag_errs=%0d, expected %0d/1/0",
               name, fd, nd, be, LAT);
    end
    tests_run++;
    if ({hi, lo} !== exp || ad !== d) begin
      tests_failed++;
      $display("FAIL %s_result: got hi:lo=%h:%h addr=%h, expected %h addr=%h",
               name, hi, lo, ad, exp, d);
    end
  endtask

  task automatic test_directed;
    check_op("a3_b5", 16'd3, 16'd5, 8'h11, 1'b0);
    check_op("ffff_sq", 16'hFFFF, 16'hFFFF, 8'h22, 1'b0);
    check_op("zero_b", 16'h1234, 16'h0000, 8'h33, 1'b0);
`ifndef MUL_SEQ_SIGNED_EN
    tests_run++;
    if (res_hi !== 16'h0 || res_lo !== 16'h0) begin
      tests_failed++;
      $display("FAIL zero_b_hold: got %h:%h expected 0000:0000", res_hi, res_lo);
    end
    check_op("ffff_sq2", 16'hFFFF, 16'hFFFF, 8'h44, 1'b0);
    tests_run++;
    if (res_hi !== 16'hFFFE || res_lo !== 16'h0001) begin
      tests_failed++;
      $display("FAIL ffff_const: got %h:%h expected FFFE:0001", res_hi, res_lo);
    end
`endif
  endtask

  task automatic test_random;
    for (int i = 0; i < 12; i++) begin
      check_op("random", 16'($urandom), 16'($urandom), 8'($urandom), 1'b0);
    end
  endtask

  task automatic test_abort;
    int fd, nd, be;
    logic [15:0] lo, hi, prev_lo, prev_hi;
    logic [7:0] ad;
    prev_lo = res_lo; prev_hi = res_hi;
    run_op(16'h5555, 16'h3333, 8'h55, 1'b0, 4, -1, -1, fd, nd, be, lo, hi, ad);
    tests_run++;
    if (nd != 0 || be != 0) begin
      tests_failed++;
      $display("FAIL abort_no_write: got dones=%0d flag_errs=%0d, expected 0/0", nd, be);
    end
    tests_run++;
    if (res_lo !== prev_lo || res_hi !== prev_hi) begin
      tests_failed++;
      $display("FAIL abort_hold: got %h:%h expected %h:%h", res_hi, res_lo, prev_hi, prev_lo);
    end
    check_op("after_abort", 16'd7, 16'd6, 8'h66, 1'b0);
    tests_run++;
    if (res_lo !== 16'h002A) begin
      tests_failed++;
      $display("FAIL after_abort_const: got %h expected 002A", res_lo);
    end
  endtask

  task automatic test_back_to_back;
    int fd, nd, be;
    logic [15:0] lo, hi;
    logic [7:0] ad;
    logic [31:0] exp;
    exp = model_product(16'h0123, 16'h0456);
    run_op(16'h0123, 16'h0456, 8'h77, 1'b0, -1, 3, 9, fd, nd, be, lo, hi, ad);
    tests_run++;
    if (nd != 1 || fd != LAT || be != 0 || {hi, lo} !== exp) begin
      tests_failed++;
      $display("FAIL restart_ignored: got dones=%0d cycle=%0d errs=%0d prod=%h, expected 1/%0d/0/%h",
               nd, fd, be, {hi, lo}, LAT, exp);
    end
  endtask

  task automatic test_reset_mid;
    int nd;
    op_a = 16'h00FF; op_b = 16'h00FF; dest = 8'h99; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({busy, done, we, me} !== 4'b0 || waddr !== 8'h0 || res_lo !== 16'h0 || res_hi !== 16'h0)
    begin
      tests_failed++;
      $display("FAIL reset_async: got flags=%b addr=%h lo=%h hi=%h, expected all 0",
               {busy, done, we, me}, waddr, res_lo, res_hi);
    end
    @(negedge clk) rst = 1'b0;
    nd = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      if (done || we || me || busy) nd++;
    end
    tests_run++;
    if (nd != 0) begin
      tests_failed++;
      $display("FAIL reset_no_write: got %0d active cycles, expected 0", nd);
    end
  endtask

  task automatic test_start_abort;
    check_op("start_abort", 16'h0F0F, 16'h00F3, 8'hAA, 1'b1);
  endtask

`ifdef MUL_SEQ_SIGNED_EN
  task automatic test_signed;
    check_op("neg3_x5", 16'hFFFD, 16'd5, 8'h01, 1'b0);
    tests_run++;
    if (res_lo !== 16'hFFF1 || res_hi !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL signed_const1: got %h:%h expected FFFF:FFF1", res_hi, res_lo);
    end
    check_op("neg4_sq", 16'hFFFC, 16'hFFFC, 8'h02, 1'b0);
    tests_run++;
    if (res_lo !== 16'h0010 || res_hi !== 16'h0000) begin
      tests_failed++;
      $display("FAIL signed_const2: got %h:%h expected 0000:0010", res_hi, res_lo);
    end
    check_op("min_neg", 16'h8000, 16'h8000, 8'h03, 1'b0);
  endtask
`endif

  initial begin
    #12;
    test_reset();
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    test_directed();
    test_random();
    test_abort();
    test_back_to_back();
    test_start_abort();
`ifdef MUL_SEQ_SIGNED_EN
    test_signed();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
